// File: rtl/ysyx_23060096_addsub_pipe_pkg.sv
// Shared widths, op encodings and result-entry layout for the add/sub pipe.
package ysyx_23060096_addsub_pipe_pkg;

  localparam int unsigned W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carry;
  } res_entry_t;

endpackage

// File: rtl/ysyx_23060096_adder.sv
// Combinational 4-bit add/sub with zero/overflow/carry flags.
module ysyx_23060096_adder
  import ysyx_23060096_addsub_pipe_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output res_entry_t   entry_c
);

  logic [W-1:0] t;
  logic [W:0]   sum;

  // Subtract is A + ~B + 1; op doubles as the carry-in.
  always_comb begin
    t       = b ^ {W{op}};
    sum     = {1'b0, a} + {1'b0, t} + (W+1)'(op);
    entry_c = '0;
    entry_c.result   = sum[W-1:0];
    entry_c.carry    = sum[W];
    entry_c.overflow = (a[W-1] == t[W-1]) && (sum[W-1] != a[W-1]);
    entry_c.zero     = (sum[W-1:0] == '0);
  end

endmodule

// File: rtl/ysyx_23060096_addsub_pipe.sv
// Operand register -> adder -> DEPTH-entry result FIFO, with sticky overflow
// and an output handshake counter.
module ysyx_23060096_addsub_pipe
  import ysyx_23060096_addsub_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_zero,
  output logic         out_overflow,
  output logic         out_carry,
  output logic         sticky_ovf,
  input  logic         clr_sticky,
  output logic [7:0]   op_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          s1_op;
  logic          s1_valid;
  res_entry_t    s1_entry;
  res_entry_t    buf_q [DEPTH];
  res_entry_t    head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic          can_accept;
  logic          accept;

  ysyx_23060096_adder u_adder (
    .a       (s1_a),
    .b       (s1_b),
    .op      (s1_op),
    .entry_c (s1_entry)
  );

  // A full buffer still takes a push when the head leaves on the same edge.
  always_comb begin
    out_valid  = !rst && (count != '0);
    pop        = out_valid && out_ready;
    can_accept = (count < FULL) || pop;
    push       = s1_valid && can_accept;
    in_ready   = !rst && (!s1_valid || can_accept);
    accept     = in_valid && in_ready;
    head       = buf_q[rd_ptr];
  end

  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_overflow = head.overflow;
  assign out_carry    = head.carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      buf_q[wr_ptr] <= s1_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // A set wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (push && s1_entry.overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_addsub_pipe.sv
// Scoreboard bench: driver predicts results at acceptance, monitor checks pops.
module tb_ysyx_23060096_addsub_pipe;
  import ysyx_23060096_addsub_pipe_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_op = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic       out_zero;
  logic       out_overflow;
  logic       out_carry;
  logic       sticky_ovf;
  logic       clr_sticky = 1'b0;
  logic [7:0] op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_ops = 0;
  res_entry_t exp_q [$];

  ysyx_23060096_addsub_pipe #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_carry    (out_carry),
    .sticky_ovf   (sticky_ovf),
    .clr_sticky   (clr_sticky),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  function automatic res_entry_t model(input int a, input int b, input bit op);
    res_entry_t e;
    int s, sa, sb, ss;
    s  = op ? a - b : a + b;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    ss = op ? sa - sb : sa + sb;
    e.result   = 4'(s & 15);
    e.zero     = ((s & 15) == 0);
    e.overflow = (ss > 7) || (ss < -8);
    e.carry    = op ? (a >= b) : (s > 15);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle from a negedge: record the acceptance the next edge will make.
  task automatic step();
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(int'(in_a), int'(in_b), in_op));
    @(negedge clk);
  endtask

  task automatic send(input int a, input int b, input bit op, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1; in_a = 4'(a); in_b = 4'(b); in_op = op;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(model(a, b, op));
        ok = 1'b1;
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sticky", int'(sticky_ovf), 0);
    chk("rst_op_count", int'(op_count), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: checks op_count every cycle and each popped head against the queue.
  initial begin
    res_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        exp_ops = 0;
      end else begin
        chk("op_count", int'(op_count), exp_ops % 256);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("result", int'(out_result), int'(e.result));
            chk("zero", int'(out_zero), int'(e.zero));
            chk("overflow", int'(out_overflow), int'(e.overflow));
            chk("carry", int'(out_carry), int'(e.carry));
          end
          exp_ops++;
        end
      end
    end
  end

  initial begin
    int waited;
    int idx;
    int acc;
    @(negedge clk);
    do_reset();

    // 7+1 overflows; first acceptance must land on the first edge out of reset.
    out_ready = 1'b1;
    send(7, 1, 1'b0, waited);
    chk("first_accept_wait", waited, 0);
    step();
    chk("sticky_after_ovf", int'(sticky_ovf), 1);
    drain();

    // 3-3: out_valid rises exactly two edges after acceptance.
    send(3, 3, 1'b1, waited);
    #1 chk("lat_edge1_valid", int'(out_valid), 0);
    step();
    #1 chk("lat_edge2_valid", int'(out_valid), 1);
    chk("lat_zero", int'(out_zero), 1);
    drain();

    // Backpressure: DEPTH+1 requests fit, the rest wait until out_ready returns.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 4);
      in_a = 4'(idx + 1); in_b = 4'(idx + 1); in_op = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(idx + 1, idx + 1, 1'b0));
        idx++;
      end
      @(negedge clk);
    end
    #1;
    chk("stall_accepted", idx, DEPTH + 1);
    chk("stall_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    send(4, 4, 1'b0, waited);
    drain();

    // Clear racing an overflowing push: the set wins, a lone clear then clears.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    #1 chk("sticky_cleared_pre", int'(sticky_ovf), 0);
    send(4, 4, 1'b0, waited);
    clr_sticky = 1'b1;
    step();
    #1 chk("sticky_set_wins", int'(sticky_ovf), 1);
    step();
    clr_sticky = 1'b0;
    #1 chk("sticky_clear_alone", int'(sticky_ovf), 0);
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_a      = 4'($urandom_range(15));
      in_b      = 4'($urandom_range(15));
      in_op     = 1'($urandom_range(1));
      out_ready = ($urandom_range(2) != 0);
      step();
    end
    in_valid = 1'b0;
    drain();

    // 256 handshakes from reset wrap op_count to 0.
    do_reset();
    out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 600 && acc < 256; c++) begin
      in_valid = 1'b1;
      in_a = 4'($urandom_range(15)); in_b = 4'($urandom_range(15));
      in_op = 1'($urandom_range(1));
      #1;
      if (in_ready) begin
        exp_q.push_back(model(int'(in_a), int'(in_b), in_op));
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    chk("wrap_accepted", acc, 256);
    #1 chk("op_count_wrap", int'(op_count), 0);

    // Reset with two entries buffered discards them and clears op_count.
    for (int i = 0; i < 3; i++) send(i, 1, 1'b0, waited);
    drain();
    out_ready = 1'b0;
    send(5, 2, 1'b1, waited);
    send(6, 1, 1'b0, waited);
    step();
    #1 chk("prereset_buffered", int'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postreset_out_valid", int'(out_valid), 0);
    chk("postreset_op_count", int'(op_count), 0);
    @(negedge clk);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
